find_min_k_stream: RTL and testbench
====================================

# find_min_k_stream

Streaming top-K minimum finder: accepts a frame of N samples over a valid/ready handshake and keeps a sorted table of the K smallest values with their in-frame indices. It generalises the fixed two-minimum finder in depth (N), width (W) and tracked-minimum count (K). It adds framed start/done control, back-pressure and deterministic tie handling, and sits between a sample source and any consumer of ranked minima.

## Interface
- W, 4, sample width in bits
- N, 10, samples per frame; N >= K, N >= 2
- K, 2, number of minima tracked; K >= 1
- IW, $clog2(N), index width (derived, not overridden)

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin new frame (clears table and count)
- valid_i  in  1  data_i valid
- data_i  in  W  unsigned sample
- ready_o  out  1  block accepts a sample this cycle
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse, frame complete
- cnt_o  out  IW+1  samples accepted in current frame
- min_o  out  K x W  ascending minima; min_o[0] is smallest
- idx_o  out  K x IW  frame index of each min_o entry

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready_o=0, busy_o=0. start_i -> RUN. The table is cleared: entry valid bits=0, min_o all ones, idx_o all ones, cnt_o=0.
- RUN: ready_o=1, busy_o=1. A sample is accepted when valid_i & ready_o, at index p=cnt_o.
- Insertion: j = number of valid entries with min[e] <= data_i. Comparison is unsigned and all K entries are compared in parallel.
  - Invalid entries rank above any value, so an all-ones sample is still inserted.
  - Entries j..K-2 shift to j+1. Entry K-1 is dropped. Entry j gets {data_i, p, valid=1}.
  - j==K: sample discarded; cnt_o still increments.
- Ties: an earlier index ranks first (stable), because of the <= rule.
- Acceptance at p==N-1 -> DONE.
- DONE: lasts exactly one cycle. done_o=1, ready_o=0, busy_o=0. Next state is IDLE, or RUN if start_i=1.
- start_i in RUN: table and count cleared; state stays RUN. A sample accepted in the same cycle is discarded.
- min_o, idx_o and cnt_o hold after DONE until the next start_i.
- valid_i and data_i are ignored outside RUN.

## Timing
- Reset values (asynchronous, immediate on rst_i):
  - state IDLE
  - ready_o=0, busy_o=0, done_o=0, cnt_o=0
  - min_o all ones, idx_o all ones, all entry valid bits 0
- Reset mid-frame: abandons the frame. There is no done_o pulse.
- start_i -> ready_o=1 on the next cycle.
- An accepted sample is reflected in min_o, idx_o and cnt_o after the same clock edge (1-cycle latency).
- done_o rises in the cycle after the edge that accepts sample N-1, with final results already stable.
- Throughput: one sample per cycle in RUN, no bubbles. Minimum frame period is N+1 cycles with start_i held in the DONE cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package find_min_pkg holds:
  - state enum typedef (IDLE, RUN, DONE)
  - entry struct typedef {logic valid; logic [W-1:0] val; logic [IW-1:0] idx}, parametrised through a function or a W/IW-sized localparam pattern
  - reset-entry constant
- Sub-module topk_insert_net: purely combinational.
  - Inputs: K-entry table, new sample, index.
  - Output: next table, computed from K compare bits (thermometer code) to one-hot insert position to per-entry shift/insert mux.
- Top holds the FSM, counter and table registers.

## Test plan
Defaults W=4, N=10, K=2 unless stated.
- Frame 7,3,9,1,5,8,2,6,4,0 back-to-back -> min_o={0,1}, idx_o={9,3}, done_o high exactly one cycle, one cycle after the 10th accept, cnt_o=10.
- Frame 5,2,2,9,9,9,9,9,9,9 -> min_o={2,2}, idx_o={1,2} (stable ties).
- All samples 15 -> min_o={15,15}, idx_o={0,1} (all-ones inserted via valid bits).
- Frame 1 with valid_i low every other cycle -> identical results; done_o 1 cycle after the last accept; ready_o stays 1 through gaps.
- 4 samples 0,0,0,0, then start_i, then frame 7,3,9,1,5,8,2,6,4,0 -> min_o={0,1}, idx_o={9,3}; the first four samples have no effect.
- rst_i pulsed after 5 samples -> immediately ready_o=0, busy_o=0, cnt_o=0, min_o={15,15}, idx_o={15,15}; no done_o. K=4, N=16, W=8 rerun of case 1 padded with 200s -> min_o={0,1,2,3}.

Source files
------------

// File: rtl/find_min_k_stream_pkg.sv
// Shared types and constants for the streaming top-K minimum finder.
// Table entries are packed as {valid, val[W-1:0], idx[IW-1:0]}, valid at the MSB.
package find_min_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned ENTRY_MAX_BITS = 64;

  function automatic int unsigned entry_bits(input int unsigned w, input int unsigned iw);
    return 1 + w + iw;
  endfunction

  // Cleared entry: valid=0, value and index all ones.
  function automatic logic [ENTRY_MAX_BITS-1:0] reset_entry(input int unsigned w,
                                                            input int unsigned iw);
    return (64'd1 << (w + iw)) - 64'd1;
  endfunction

endpackage

// File: rtl/find_min_k_stream_if.sv
// Sample/control/result bundle between a sample source and find_min_k_stream.
interface find_min_k_stream_if #(
  parameter int unsigned W = 4,
  parameter int unsigned N = 10,
  parameter int unsigned K = 2
);
  localparam int unsigned IW = $clog2(N);

  logic                    start_i;
  logic                    valid_i;
  logic [W-1:0]            data_i;
  logic                    ready_o;
  logic                    busy_o;
  logic                    done_o;
  logic [IW:0]             cnt_o;
  logic [K-1:0][W-1:0]     min_o;
  logic [K-1:0][IW-1:0]    idx_o;

  modport master (
    output start_i, valid_i, data_i,
    input  ready_o, busy_o, done_o, cnt_o, min_o, idx_o
  );

  modport slave (
    input  start_i, valid_i, data_i,
    output ready_o, busy_o, done_o, cnt_o, min_o, idx_o
  );
endinterface

// File: rtl/find_min_k_stream_topk_insert_net.sv
// Combinational sorted-table insert: thermometer compare -> one-hot position -> shift/insert mux.
module topk_insert_net #(
  parameter int unsigned W  = 4,
  parameter int unsigned IW = 4,
  parameter int unsigned K  = 2
) (
  input  logic [K*(1+W+IW)-1:0] tbl_i,
  input  logic [W-1:0]          data_i,
  input  logic [IW-1:0]         idx_i,
  output logic [K*(1+W+IW)-1:0] tbl_o
);
  typedef struct packed {
    logic          valid;
    logic [W-1:0]  val;
    logic [IW-1:0] idx;
  } entry_t;

  entry_t [K-1:0] cur;
  entry_t [K-1:0] nxt;
  entry_t         ins;
  logic   [K-1:0] keep;
  logic   [K-1:0] put;

  assign cur   = tbl_i;
  assign ins   = '{valid: 1'b1, val: data_i, idx: idx_i};
  assign tbl_o = nxt;

  // Valid entries are contiguous and sorted, so keep[] is a thermometer code;
  // using <= places a new sample after equal values, keeping ties stable.
  always_comb begin
    keep = '0;
    put  = '0;
    nxt  = cur;
    for (int unsigned e = 0; e < K; e++) begin
      keep[e] = cur[e].valid && (cur[e].val <= data_i);
    end
    put[0] = !keep[0];
    for (int unsigned e = 1; e < K; e++) begin
      put[e] = !keep[e] && keep[e-1];
    end
    nxt[0] = put[0] ? ins : cur[0];
    for (int unsigned e = 1; e < K; e++) begin
      if (keep[e])     nxt[e] = cur[e];
      else if (put[e]) nxt[e] = ins;
      else             nxt[e] = cur[e-1];
    end
  end
endmodule

// File: rtl/find_min_k_stream.sv
// Streaming top-K minimum finder: frame FSM, sample counter and sorted minima table.
module find_min_k_stream
  import find_min_pkg::*;
#(
  parameter int unsigned W = 4,
  parameter int unsigned N = 10,
  parameter int unsigned K = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  find_min_k_stream_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned EB = entry_bits(W, IW);

  localparam logic [ENTRY_MAX_BITS-1:0] RST_WIDE  = reset_entry(W, IW);
  localparam logic [EB-1:0]             RST_ENTRY = RST_WIDE[EB-1:0];
  localparam logic [K*EB-1:0]           RST_TABLE = {K{RST_ENTRY}};
  localparam logic [IW:0]               LAST_IDX  = (IW+1)'(N - 1);

  state_e          state_q, state_d;
  logic [IW:0]     cnt_q, cnt_d;
  logic [K*EB-1:0] tbl_q, tbl_d, tbl_ins;

  topk_insert_net #(.W(W), .IW(IW), .K(K)) u_insert (
    .tbl_i  (tbl_q),
    .data_i (bus.data_i),
    .idx_i  (cnt_q[IW-1:0]),
    .tbl_o  (tbl_ins)
  );

  // start_i has priority over a same-cycle sample in RUN: the sample is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tbl_d   = tbl_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          tbl_d   = RST_TABLE;
        end
      end
      RUN: begin
        if (bus.start_i) begin
          cnt_d = '0;
          tbl_d = RST_TABLE;
        end else if (bus.valid_i) begin
          cnt_d = cnt_q + 1'b1;
          tbl_d = tbl_ins;
          if (cnt_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          tbl_d   = RST_TABLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tbl_q   <= RST_TABLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tbl_q   <= tbl_d;
    end
  end

  assign bus.ready_o = (state_q == RUN);
  assign bus.busy_o  = (state_q == RUN);
  assign bus.done_o  = (state_q == DONE);
  assign bus.cnt_o   = cnt_q;

  for (genvar e = 0; e < K; e++) begin : g_out
    assign bus.min_o[e] = tbl_q[e*EB + IW +: W];
    assign bus.idx_o[e] = tbl_q[e*EB +: IW];
  end
endmodule

// File: tb/tb_find_min_k_stream.sv
// Directed self-checking bench: a K=2/N=10/W=4 instance and a K=4/N=16/W=8 instance.
module tb_find_min_k_stream;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  find_min_k_stream_if #(.W(4), .N(10), .K(2)) ifa ();
  find_min_k_stream_if #(.W(8), .N(16), .K(4)) ifb ();

  find_min_k_stream #(.W(4), .N(10), .K(2)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa.slave)
  );

  find_min_k_stream #(.W(8), .N(16), .K(4)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] frame;   // sample i in bits [4*i +: 4]
    bit          gap;
    logic [7:0]  mins;    // {min_o[1], min_o[0]}
    logic [7:0]  idxs;    // {idx_o[1], idx_o[0]}
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a frame on dut_a and feeds all 10 samples; ends in the DONE cycle.
  task automatic run_a(input logic [39:0] frame, input bit gap);
    ifa.start_i = 1'b1;
    ifa.valid_i = 1'b0;
    tick();
    ifa.start_i = 1'b0;
    check("start_ready", ifa.ready_o, 1);
    check("start_busy", ifa.busy_o, 1);
    check("start_cnt", ifa.cnt_o, 0);
    check("start_min", ifa.min_o, 8'hFF);
    check("start_idx", ifa.idx_o, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      if (gap && i > 0) begin
        ifa.valid_i = 1'b0;
        ifa.data_i  = 4'd0;
        tick();
        check("gap_ready", ifa.ready_o, 1);
      end
      ifa.valid_i = 1'b1;
      ifa.data_i  = frame[4*i +: 4];
      tick();
      ifa.valid_i = 1'b0;
      check("acc_cnt", ifa.cnt_o, 64'(i + 1));
      check("acc_done", ifa.done_o, (i == 9) ? 1 : 0);
    end
    check("done_ready", ifa.ready_o, 0);
    check("done_busy", ifa.busy_o, 0);
  endtask

  logic [7:0] fb[16];
  int         done_seen;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    ifa.start_i = 1'b0; ifa.valid_i = 1'b0; ifa.data_i = '0;
    ifb.start_i = 1'b0; ifb.valid_i = 1'b0; ifb.data_i = '0;

    vecs[0] = '{40'h0462851937, 1'b0, 8'h10, 8'h39};
    vecs[1] = '{40'h9999999225, 1'b0, 8'h22, 8'h21};
    vecs[2] = '{40'hFFFFFFFFFF, 1'b0, 8'hFF, 8'h10};
    vecs[3] = '{40'h0462851937, 1'b1, 8'h10, 8'h39};

    #2;
    check("rst_ready", ifa.ready_o, 0);
    check("rst_busy", ifa.busy_o, 0);
    check("rst_done", ifa.done_o, 0);
    check("rst_cnt", ifa.cnt_o, 0);
    check("rst_min", ifa.min_o, 8'hFF);
    check("rst_idx", ifa.idx_o, 8'hFF);
    check("rst_min_b", ifb.min_o, 32'hFFFFFFFF);
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      run_a(vecs[v].frame, vecs[v].gap);
      check("vec_min", ifa.min_o, vecs[v].mins);
      check("vec_idx", ifa.idx_o, vecs[v].idxs);
      tick();
      check("post_done", ifa.done_o, 0);
      check("hold_min", ifa.min_o, vecs[v].mins);
      check("hold_idx", ifa.idx_o, vecs[v].idxs);
      check("hold_cnt", ifa.cnt_o, 10);
    end

    // Back-to-back frames with start_i held in the DONE cycle.
    run_a(vecs[1].frame, 1'b0);
    run_a(vecs[0].frame, 1'b0);
    check("b2b_min", ifa.min_o, 8'h10);
    check("b2b_idx", ifa.idx_o, 8'h39);
    tick();

    // Samples offered while idle are ignored.
    for (int i = 0; i < 4; i++) begin
      ifa.valid_i = 1'b1;
      ifa.data_i  = 4'd0;
      tick();
    end
    ifa.valid_i = 1'b0;
    check("idle_cnt", ifa.cnt_o, 10);
    check("idle_min", ifa.min_o, 8'h10);
    check("idle_ready", ifa.ready_o, 0);

    // Four zeros in RUN, then a restart that swallows a same-cycle sample.
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifa.valid_i = 1'b1;
      ifa.data_i  = 4'd0;
      tick();
    end
    check("pre_cnt", ifa.cnt_o, 4);
    check("pre_min", ifa.min_o, 8'h00);
    ifa.start_i = 1'b1;
    ifa.valid_i = 1'b1;
    ifa.data_i  = 4'd0;
    tick();
    ifa.start_i = 1'b0;
    ifa.valid_i = 1'b0;
    check("restart_cnt", ifa.cnt_o, 0);
    check("restart_min", ifa.min_o, 8'hFF);
    check("restart_busy", ifa.busy_o, 1);
    run_a(vecs[0].frame, 1'b0);
    check("restart_fmin", ifa.min_o, 8'h10);
    check("restart_fidx", ifa.idx_o, 8'h39);
    tick();

    // Reset pulsed mid-frame abandons it with no done pulse.
    ifa.start_i = 1'b1;
    tick();
    ifa.start_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ifa.valid_i = 1'b1;
      ifa.data_i  = 4'(i + 2);
      tick();
    end
    ifa.valid_i = 1'b0;
    check("mid_cnt", ifa.cnt_o, 5);
    rst = 1'b1;
    #1;
    check("mrst_ready", ifa.ready_o, 0);
    check("mrst_busy", ifa.busy_o, 0);
    check("mrst_cnt", ifa.cnt_o, 0);
    check("mrst_min", ifa.min_o, 8'hFF);
    check("mrst_idx", ifa.idx_o, 8'hFF);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      ifa.valid_i = 1'b1;
      ifa.data_i  = 4'd1;
      tick();
      if (ifa.done_o) done_seen++;
    end
    ifa.valid_i = 1'b0;
    check("mrst_no_done", 64'(done_seen), 0);
    check("mrst_idle_cnt", ifa.cnt_o, 0);

    // Wider instance: K=4, N=16, W=8.
    fb = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6,
           8'd4, 8'd0, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200};
    ifb.start_i = 1'b1;
    tick();
    ifb.start_i = 1'b0;
    check("b_ready", ifb.ready_o, 1);
    for (int i = 0; i < 16; i++) begin
      ifb.valid_i = 1'b1;
      ifb.data_i  = fb[i];
      tick();
      check("b_done", ifb.done_o, (i == 15) ? 1 : 0);
    end
    ifb.valid_i = 1'b0;
    check("b_cnt", ifb.cnt_o, 16);
    check("b_min", ifb.min_o, 32'h03020100);
    check("b_idx", ifb.idx_o, 16'h1639);
    tick();
    check("b_post_done", ifb.done_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
